// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter for a single-port synchronous SRAM with 1-cycle read latency.
// Data side wins by default; a burst limiter forces an IF grant after MAX_D_BURST data wins.
module sram_port_arbiter #(
   parameter int MAX_D_BURST = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   input  logic        if_kill,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic [3:0]  d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        sram_en,
   output logic [3:0]  sram_we,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata
);

   localparam logic [3:0] MAX_CNT = 4'(MAX_D_BURST);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_D    = 2'd2
   } owner_t;

   owner_t     owner;
   owner_t     owner_next;
   logic [3:0] burst_cnt;
   logic       force_if;
   logic       d_read;

   assign force_if = (burst_cnt == MAX_CNT);
   assign d_read   = (d_we == 4'b0000);

   // Request stage: combinational grant, never both, nothing while in reset
   always_comb begin
      if_gnt = 1'b0;
      d_gnt  = 1'b0;
      if (!reset) begin
         if (if_req && d_req) begin
            if_gnt = force_if;
            d_gnt  = !force_if;
         end else begin
            if_gnt = if_req;
            d_gnt  = d_req;
         end
      end
   end

   always_comb begin
      sram_en    = if_gnt | d_gnt;
      sram_we    = 4'b0000;
      sram_addr  = 32'h0000_0000;
      sram_wdata = 32'h0000_0000;
      if (if_gnt) begin
         sram_addr = if_addr;
      end else if (d_gnt) begin
         sram_we    = d_we;
         sram_addr  = d_addr;
         sram_wdata = d_wdata;
      end
   end

   // Counts data wins while IF is waiting; any IF grant or IF going idle restarts the window
   always_ff @(posedge clk) begin
      if (reset) begin
         burst_cnt <= 4'd0;
      end else if (if_gnt || !if_req) begin
         burst_cnt <= 4'd0;
      end else if (d_gnt && (burst_cnt != MAX_CNT)) begin
         burst_cnt <= burst_cnt + 4'd1;
      end
   end

   // Response stage: owner of the read whose data appears on sram_rdata this cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         owner <= OWN_NONE;
      end else begin
         owner <= owner_next;
      end
   end

   always_comb begin
      owner_next = OWN_NONE;
      if (if_gnt && !if_kill) begin
         owner_next = OWN_IF;
      end else if (d_gnt && d_read) begin
         owner_next = OWN_D;
      end
   end

   // A kill in the response cycle still drops an IF read already on its way back
   always_comb begin
      if_rvalid = (owner == OWN_IF) && !if_kill && !reset;
      d_rvalid  = (owner == OWN_D) && !reset;
   end

   assign if_rdata = sram_rdata;
   assign d_rdata  = sram_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model, with a behavioural SRAM attached.
module tb_sram_port_arbiter;

   localparam int MAX_D_BURST = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, if_kill, if_gnt, if_rvalid;
   logic [31:0] if_addr, if_rdata;
   logic        d_req, d_gnt, d_rvalid;
   logic [3:0]  d_we;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        sram_en;
   logic [3:0]  sram_we;
   logic [31:0] sram_addr, sram_wdata;
   logic [31:0] sram_rdata = 32'h0;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sram_port_arbiter #(.MAX_D_BURST(MAX_D_BURST)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
      .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
      .sram_rdata(sram_rdata)
   );

   // Behavioural SRAM and an independent reference copy kept by the model
   bit [31:0] sram_mem [bit [29:0]];
   bit [31:0] ref_mem  [bit [29:0]];

   function automatic bit [31:0] dflt(bit [29:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5a5a_0000;
   endfunction

   function automatic bit [31:0] merge(bit [31:0] old, bit [31:0] nw, bit [3:0] be);
      bit [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   always @(posedge clk) begin
      if (sram_en) begin
         if (sram_we == 4'b0)
            sram_rdata <= sram_mem.exists(sram_addr[31:2]) ? sram_mem[sram_addr[31:2]] : dflt(sram_addr[31:2]);
         else
            sram_mem[sram_addr[31:2]] = merge(sram_mem.exists(sram_addr[31:2]) ? sram_mem[sram_addr[31:2]]
                                              : dflt(sram_addr[31:2]), sram_wdata, sram_we);
      end
   end

   function automatic bit [31:0] ref_rd(bit [31:0] a);
      return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : dflt(a[31:2]);
   endfunction

   // Transaction-level model: who wins, what the SRAM sees, which response comes back next
   int        streak;          // data wins since IF last got in while IF kept asking
   int        pend;            // 0 none, 1 IF read in flight, 2 D read in flight
   bit [31:0] pend_data;
   bit        e_if_gnt, e_d_gnt, e_if_rvalid, e_d_rvalid;
   bit [31:0] e_addr, e_wdata;
   bit [3:0]  e_we;

   task automatic model_eval();
      e_if_gnt = 0;
      e_d_gnt  = 0;
      if (!reset) begin
         if (if_req && d_req) begin
            e_if_gnt = (streak >= MAX_D_BURST);
            e_d_gnt  = !e_if_gnt;
         end else begin
            e_if_gnt = if_req;
            e_d_gnt  = d_req;
         end
      end
      e_addr  = e_if_gnt ? if_addr : (e_d_gnt ? d_addr : 32'h0);
      e_we    = e_d_gnt ? d_we : 4'h0;
      e_wdata = e_d_gnt ? d_wdata : 32'h0;
      e_if_rvalid = !reset && pend == 1 && !if_kill;
      e_d_rvalid  = !reset && pend == 2;
   endtask

   task automatic model_step();
      if (reset) begin
         pend   = 0;
         streak = 0;
      end else begin
         pend      = (e_if_gnt && !if_kill) ? 1 : ((e_d_gnt && d_we == 4'h0) ? 2 : 0);
         pend_data = ref_rd(e_addr);
         if (e_d_gnt && d_we != 4'h0) ref_mem[d_addr[31:2]] = merge(ref_rd(d_addr), d_wdata, d_we);
         if (e_if_gnt || !if_req) streak = 0;
         else if (e_d_gnt && streak < MAX_D_BURST) streak++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      if_req = 0; if_kill = 0; d_req = 0; d_we = 0;
      if_addr = 0; d_addr = 0; d_wdata = 0;
   endtask

   task automatic test_reset();
      reset = 1; idle(); if_req = 1; d_req = 1;
      @(negedge clk);
      checks++;
      if ({if_gnt, d_gnt, sram_en} !== 3'b000) begin
         failures++; $display("FAIL reset_grants: got %b expected 000", {if_gnt, d_gnt, sram_en});
      end
      tick(); tick();
      reset = 0; idle();
      @(negedge clk);
      checks++;
      if ({if_rvalid, d_rvalid} !== 2'b00) begin
         failures++; $display("FAIL reset_rvalid: got %b expected 00", {if_rvalid, d_rvalid});
      end
      checks++;
      if (dut.burst_cnt !== 4'd0) begin
         failures++; $display("FAIL reset_burst_cnt: got %0d expected 0", dut.burst_cnt);
      end
      tick();
   endtask

   task automatic test_if_only();
      if_req = 1; if_addr = 32'h1c00_0000;
      @(negedge clk);
      checks++;
      if ({if_gnt, d_gnt, sram_en, sram_we} !== 7'b1010000 || sram_addr !== 32'h1c00_0000) begin
         failures++; $display("FAIL if_only_grant0: got gnt/en/we %b addr %h expected 1010000 addr 1c000000",
                              {if_gnt, d_gnt, sram_en, sram_we}, sram_addr);
      end
      tick();
      if_addr = 32'h1c00_0004;
      @(negedge clk);
      checks++;
      if (if_gnt !== 1'b1 || sram_addr !== 32'h1c00_0004) begin
         failures++; $display("FAIL if_only_grant1: got gnt %b addr %h expected 1 1c000004", if_gnt, sram_addr);
      end
      checks++;
      if (if_rvalid !== 1'b1 || if_rdata !== 32'h0280_0c0c) begin
         failures++; $display("FAIL if_only_resp0: got %b %h expected 1 02800c0c", if_rvalid, if_rdata);
      end
      tick();
      idle();
      @(negedge clk);
      checks++;
      if (if_rvalid !== 1'b1 || if_rdata !== 32'h0280_1010 || d_rvalid !== 1'b0) begin
         failures++; $display("FAIL if_only_resp1: got %b %h d_rvalid %b expected 1 02801010 0",
                              if_rvalid, if_rdata, d_rvalid);
      end
      tick();
   endtask

   task automatic test_write_read();
      d_req = 1; d_we = 4'hf; d_addr = 32'h100; d_wdata = 32'hdead_beef;
      @(negedge clk);
      checks++;
      if (d_gnt !== 1'b1 || sram_we !== 4'hf || sram_wdata !== 32'hdead_beef || sram_addr !== 32'h100) begin
         failures++; $display("FAIL wr_grant: got gnt %b we %h wdata %h addr %h expected 1 f deadbeef 100",
                              d_gnt, sram_we, sram_wdata, sram_addr);
      end
      tick();
      d_we = 4'h0; d_wdata = 32'h0;
      @(negedge clk);
      checks++;
      if (d_gnt !== 1'b1 || d_rvalid !== 1'b0 || sram_we !== 4'h0) begin
         failures++; $display("FAIL rd_grant: got gnt %b rvalid %b we %h expected 1 0 0", d_gnt, d_rvalid, sram_we);
      end
      tick();
      idle();
      @(negedge clk);
      checks++;
      if (d_rvalid !== 1'b1 || d_rdata !== 32'hdead_beef) begin
         failures++; $display("FAIL rd_resp: got %b %h expected 1 deadbeef", d_rvalid, d_rdata);
      end
      tick();
   endtask

   task automatic test_contention();
      bit exp_if;
      if_req = 1; if_addr = 32'h1c00_0000; d_req = 1; d_we = 0; d_addr = 32'h104;
      for (int k = 0; k < 6; k++) begin
         exp_if = (k == 4);
         @(negedge clk);
         checks++;
         if ({if_gnt, d_gnt} !== {exp_if, !exp_if}) begin
            failures++; $display("FAIL contention_gnt%0d: got if/d %b expected %b", k, {if_gnt, d_gnt}, {exp_if, !exp_if});
         end
         if (k == 5) begin
            checks++;
            if (dut.burst_cnt !== 4'd0) begin
               failures++; $display("FAIL contention_cnt_clear: got %0d expected 0", dut.burst_cnt);
            end
         end
         tick();
      end
      idle();
      tick();
   endtask

   task automatic test_kill();
      if_req = 1; if_addr = 32'h1c00_0000;
      @(negedge clk);
      checks++;
      if (if_gnt !== 1'b1 || sram_en !== 1'b1) begin
         failures++; $display("FAIL kill_late_grant: got gnt %b en %b expected 1 1", if_gnt, sram_en);
      end
      tick();
      if_req = 0; if_kill = 1;
      @(negedge clk);
      checks++;
      if (if_rvalid !== 1'b0) begin
         failures++; $display("FAIL kill_late_resp: got %b expected 0", if_rvalid);
      end
      tick();
      if_req = 1; if_kill = 1;
      @(negedge clk);
      checks++;
      if (if_gnt !== 1'b1 || sram_en !== 1'b1) begin
         failures++; $display("FAIL kill_early_grant: got gnt %b en %b expected 1 1", if_gnt, sram_en);
      end
      tick();
      idle();
      @(negedge clk);
      checks++;
      if (if_rvalid !== 1'b0) begin
         failures++; $display("FAIL kill_early_resp: got %b expected 0", if_rvalid);
      end
      tick();
   endtask

   task automatic test_mixed();
      if_req = 1; if_addr = 32'h1c00_0004;
      @(negedge clk);
      checks++;
      if (if_gnt !== 1'b1) begin
         failures++; $display("FAIL mixed_if_gnt: got %b expected 1", if_gnt);
      end
      tick();
      if_req = 0; d_req = 1; d_we = 0; d_addr = 32'h100;
      @(negedge clk);
      checks++;
      if ({d_gnt, if_rvalid, d_rvalid} !== 3'b110 || if_rdata !== 32'h0280_1010) begin
         failures++; $display("FAIL mixed_if_resp: got gnt/ifv/dv %b data %h expected 110 02801010",
                              {d_gnt, if_rvalid, d_rvalid}, if_rdata);
      end
      tick();
      idle(); if_kill = 1;
      @(negedge clk);
      checks++;
      if ({if_rvalid, d_rvalid} !== 2'b01 || d_rdata !== 32'hdead_beef) begin
         failures++; $display("FAIL mixed_d_resp: got ifv/dv %b data %h expected 01 deadbeef",
                              {if_rvalid, d_rvalid}, d_rdata);
      end
      tick();
      idle();
   endtask

   task automatic test_reset_mid();
      d_req = 1; d_we = 0; d_addr = 32'h100;
      @(negedge clk);
      checks++;
      if (d_gnt !== 1'b1) begin
         failures++; $display("FAIL rstmid_gnt: got %b expected 1", d_gnt);
      end
      tick();
      reset = 1;
      @(negedge clk);
      checks++;
      if ({d_rvalid, sram_en, d_gnt} !== 3'b000) begin
         failures++; $display("FAIL rstmid_during: got dv/en/gnt %b expected 000", {d_rvalid, sram_en, d_gnt});
      end
      tick();
      reset = 0; idle();
      @(negedge clk);
      checks++;
      if ({if_rvalid, d_rvalid} !== 2'b00 || dut.burst_cnt !== 4'd0) begin
         failures++; $display("FAIL rstmid_after: got rvalids %b cnt %0d expected 00 0", {if_rvalid, d_rvalid}, dut.burst_cnt);
      end
      tick();
   endtask

   task automatic test_random();
      reset = 1; idle();
      @(negedge clk); model_eval(); @(posedge clk); model_step(); #1;
      reset = 0;
      for (int c = 0; c < 500; c++) begin
         reset   = ($urandom_range(0, 59) == 0);
         if_req  = ($urandom_range(0, 3) != 0);
         d_req   = ($urandom_range(0, 3) != 0);
         if_kill = ($urandom_range(0, 6) == 0);
         d_we    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
         if_addr = 32'h100 + {26'($urandom_range(0, 15)), 2'b00};
         d_addr  = 32'h100 + {26'($urandom_range(0, 15)), 2'b00};
         d_wdata = $urandom;
         @(negedge clk);
         model_eval();
         checks++;
         if ({if_gnt, d_gnt, sram_en} !== {e_if_gnt, e_d_gnt, e_if_gnt | e_d_gnt}) begin
            failures++; $display("FAIL rnd_gnt c%0d: got %b expected %b", c, {if_gnt, d_gnt, sram_en},
                                 {e_if_gnt, e_d_gnt, e_if_gnt | e_d_gnt});
         end
         checks++;
         if ({sram_addr, sram_we, sram_wdata} !== {e_addr, e_we, e_wdata}) begin
            failures++; $display("FAIL rnd_sram c%0d: got %h/%h/%h expected %h/%h/%h", c, sram_addr, sram_we,
                                 sram_wdata, e_addr, e_we, e_wdata);
         end
         checks++;
         if ({if_rvalid, d_rvalid} !== {e_if_rvalid, e_d_rvalid}) begin
            failures++; $display("FAIL rnd_rvalid c%0d: got %b expected %b", c, {if_rvalid, d_rvalid},
                                 {e_if_rvalid, e_d_rvalid});
         end
         if (e_if_rvalid || e_d_rvalid) begin
            checks++;
            if ((e_if_rvalid ? if_rdata : d_rdata) !== pend_data) begin
               failures++; $display("FAIL rnd_rdata c%0d: got %h expected %h", c,
                                    e_if_rvalid ? if_rdata : d_rdata, pend_data);
            end
         end
         @(posedge clk);
         model_step();
         #1;
      end
      reset = 0; idle();
      tick();
   endtask

   initial begin
      sram_mem[30'h1c00_0000 >> 2] = 32'h0280_0c0c;
      sram_mem[30'h1c00_0004 >> 2] = 32'h0280_1010;
      ref_mem = sram_mem;
      streak = 0; pend = 0; pend_data = 0;
      test_reset();
      test_if_only();
      test_write_read();
      test_contention();
      test_kill();
      test_mixed();
      test_reset_mid();
      ref_mem = sram_mem;
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one synchronous single-port SRAM between two requesters: the instruction-fetch stage (IF) and the load/store stage (data, D).
- The SRAM has a fixed 1-cycle read latency. The arbiter grants at most one access per cycle and routes each read response back to its owner.
- Data accesses normally win. A burst limiter prevents IF starvation.
- A fetch-kill input lets the fetch stage discard an in-flight instruction read when a branch redirects the PC.

Parameters:
- MAX_D_BURST, 4, max consecutive D grants while if_req is pending before IF is forced a grant (legal range 1..15).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_req  in  1  IF read request
- if_addr  in  32  IF read address
- if_kill  in  1  discard IF read response due next cycle (branch redirect)
- if_gnt  out  1  IF request accepted this cycle
- if_rvalid  out  1  IF read data valid
- if_rdata  out  32  IF read data
- d_req  in  1  data request
- d_we  in  4  byte write enables; 0 = read
- d_addr  in  32  data address
- d_wdata  in  32  data write data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data read data valid
- d_rdata  out  32  data read data
- sram_en  out  1  SRAM enable
- sram_we  out  4  SRAM byte write enables
- sram_addr  out  32  SRAM address
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data, valid the cycle after an enabled read

Behaviour:
- Clock and reset: clk; reset is synchronous, active-high, applied on the rising edge.
- Grant logic is combinational in the request cycle.
  - Both requesting: d_gnt=1 unless force_if=1, in which case if_gnt=1.
  - Single requester: that requester is granted.
  - if_gnt and d_gnt are never both 1.
- SRAM drive: sram_en = if_gnt | d_gnt. Address, we and wdata come from the granted side.
  - IF grant drives sram_we=0 and sram_wdata=0.
  - No grant drives sram_en=0; addr, we and wdata = 0.
- Response tracking uses a registered owner state in {NONE, IF, D}, updated every cycle:
  - IF when if_gnt & ~if_kill
  - D when d_gnt & (d_we==0)
  - NONE otherwise (writes produce no response).
- Response outputs:
  - if_rvalid = (owner==IF) & ~if_kill. if_kill asserted in the response cycle also suppresses the response.
  - d_rvalid = (owner==D).
  - if_rdata and d_rdata both equal sram_rdata combinationally; they are meaningful only when the matching rvalid is 1.
- Kill rules:
  - if_kill in the grant cycle: the SRAM read is still issued, but no IF response is produced.
  - if_kill never affects data responses.
- Burst limiter: 4-bit counter burst_cnt.
  - Reset to 0.
  - Increments (saturating at MAX_D_BURST) on d_gnt while if_req=1.
  - Clears to 0 on if_gnt or when if_req=0.
  - force_if = (burst_cnt == MAX_D_BURST).
- Back-to-back grants each cycle are allowed (fully pipelined, throughput 1 access per cycle). A new grant may coincide with the previous read's response cycle.
- Reset values: owner=NONE, burst_cnt=0, so if_rvalid=0 and d_rvalid=0 in the cycle after reset.
  - All combinational outputs follow the inputs during reset, except that grants are forced to 0 while reset=1, hence sram_en=0.
  - Reset mid-read drops the pending response.
- Widths: all address/data fields are passed through unmodified. There is no address decoding or alignment checking (alignment is the requesters' job).

Test Plan:
- IF only, if_req=1 with addr 0x1c000000 then 0x1c000004 on consecutive cycles. Required: if_gnt=1 both cycles; sram_addr follows; if_rvalid=1 one cycle after each grant, with if_rdata = the preloaded words 0x02800c0c and 0x02801010.
- Data write then read: d_we=4'hf, addr 0x100, wdata 0xdeadbeef, then d_we=0, addr 0x100. Required: d_gnt both cycles; no d_rvalid after the write; d_rvalid=1 with 0xdeadbeef one cycle after the read grant.
- Contention with MAX_D_BURST=4: if_req and d_req held high for 6 cycles. Required grants: D,D,D,D,IF,D; burst_cnt returns to 0 after the IF grant.
- Kill: IF granted at cycle n with if_kill=1 in cycle n+1. Required: if_rvalid=0 at n+1. A second case with if_kill=1 at grant cycle n gives the same result; sram_en=1 at n in both cases.
- Mixed response: IF read granted at n, D read granted at n+1. Required: if_rvalid only at n+1, d_rvalid only at n+2, never both in the same cycle.
- Reset mid-operation: D read granted at n, reset=1 at n+1. Required: d_rvalid=0 and sram_en=0 during reset; owner=NONE and burst_cnt=0 afterwards.
